// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and sequencing controller for the five-stage core.
// Each cycle it decides whether every pipeline register advances, holds (stall)
// or loads a bubble (flush). It also keeps a saturating count of PC-stall cycles.
//
// Ports:
//   clock, reset                   rising-edge clock, async active-high reset
//   d_src_reg_1/2, d_uses_src_1/2  D-stage source indices and read enables
//   x_dst_reg, x_mem_read,         X-stage destination and control flags
//   x_reg_write, x_is_mul,
//   x_branch_taken
//   m_mem_req, m_mem_ready         M-stage data-memory handshake
//   pc/f2d/d2x/x2m_stall           hold the corresponding register
//   f2d/d2x/x2m/m2w_flush          load a bubble into the corresponding register
//   stall_cycles                   saturating count of cycles with pc_stall=1
module hazard_ctrl #(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       d_src_reg_1,
  input  logic [5:0]       d_src_reg_2,
  input  logic             d_uses_src_1,
  input  logic             d_uses_src_2,
  input  logic [5:0]       x_dst_reg,
  input  logic             x_mem_read,
  input  logic             x_reg_write,
  input  logic             x_is_mul,
  input  logic             x_branch_taken,
  input  logic             m_mem_req,
  input  logic             m_mem_ready,
  output logic             pc_stall,
  output logic             f2d_stall,
  output logic             d2x_stall,
  output logic             x2m_stall,
  output logic             f2d_flush,
  output logic             d2x_flush,
  output logic             x2m_flush,
  output logic             m2w_flush,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned MCNT_W = 4;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [MCNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

  logic mem_stall;
  logic ld_use;
  logic mul_stall;
  logic src1_hit;
  logic src2_hit;

  // Hazard detection; register 0 is hardwired zero and never conflicts.
  always_comb begin
    mem_stall = m_mem_req & ~m_mem_ready;
    src1_hit  = d_uses_src_1 & (x_dst_reg == d_src_reg_1);
    src2_hit  = d_uses_src_2 & (x_dst_reg == d_src_reg_2);
    ld_use    = x_mem_read & x_reg_write & (x_dst_reg != 6'd0) & (src1_hit | src2_hit);
  end

  // Multiply occupancy FSM; a memory wait freezes it and masks its stall.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_stall = 1'b0;
    if (!mem_stall) begin
      unique case (state_q)
        RUN: begin
          if (x_is_mul && !x_branch_taken) begin
            mul_stall = 1'b1;
            cnt_d     = MCNT_W'(MUL_LATENCY - 2);
            state_d   = MUL_WAIT;
          end
        end
        MUL_WAIT: begin
          if (cnt_q != '0) begin
            mul_stall = 1'b1;
            cnt_d     = cnt_q - MCNT_W'(1);
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Priority-encoded stall/flush outputs; reset flushes every pipeline flop.
  always_comb begin
    pc_stall  = 1'b0;
    f2d_stall = 1'b0;
    d2x_stall = 1'b0;
    x2m_stall = 1'b0;
    f2d_flush = 1'b0;
    d2x_flush = 1'b0;
    x2m_flush = 1'b0;
    m2w_flush = 1'b0;
    if (reset) begin
      f2d_flush = 1'b1;
      d2x_flush = 1'b1;
      x2m_flush = 1'b1;
      m2w_flush = 1'b1;
    end else if (mem_stall) begin
      pc_stall  = 1'b1;
      f2d_stall = 1'b1;
      d2x_stall = 1'b1;
      x2m_stall = 1'b1;
      m2w_flush = 1'b1;
    end else if (x_branch_taken) begin
      // PC loads the redirect target, so it is not stalled.
      f2d_flush = 1'b1;
      d2x_flush = 1'b1;
    end else if (mul_stall) begin
      pc_stall  = 1'b1;
      f2d_stall = 1'b1;
      d2x_stall = 1'b1;
      x2m_flush = 1'b1;
    end else if (ld_use) begin
      pc_stall  = 1'b1;
      f2d_stall = 1'b1;
      d2x_flush = 1'b1;
    end
  end

  // Saturating performance counter of PC-stall cycles.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (pc_stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: a vector table of single-cycle hazard
// patterns plus hand-written multiply, memory-wait, branch, reset and counter
// saturation sequences.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 16;

  // Output byte: {pc,f2d,d2x,x2m stall, f2d,d2x,x2m,m2w flush}
  localparam logic [7:0] O_NONE = 8'h00;
  localparam logic [7:0] O_MEM  = 8'hF1;
  localparam logic [7:0] O_BR   = 8'h0C;
  localparam logic [7:0] O_MUL  = 8'hE2;
  localparam logic [7:0] O_LU   = 8'hC4;
  localparam logic [7:0] O_RST  = 8'h0F;

  logic             clock = 1'b0;
  logic             reset;
  logic [5:0]       d_src_reg_1, d_src_reg_2, x_dst_reg;
  logic             d_uses_src_1, d_uses_src_2;
  logic             x_mem_read, x_reg_write, x_is_mul, x_branch_taken;
  logic             m_mem_req, m_mem_ready;
  logic             pc_stall, f2d_stall, d2x_stall, x2m_stall;
  logic             f2d_flush, d2x_flush, x2m_flush, m2w_flush;
  logic [CNT_W-1:0] stall_cycles;
  logic [7:0]       outs;

  int unsigned      n_cmp = 0;
  int unsigned      n_err = 0;
  logic [CNT_W-1:0] exp_cnt;

  typedef struct {
    logic [5:0] dst, s1, s2;
    logic       u1, u2, mr, rw, mul, br, mq, rdy;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[15];

  hazard_ctrl #(.MUL_LATENCY(4), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .d_src_reg_1    (d_src_reg_1),
    .d_src_reg_2    (d_src_reg_2),
    .d_uses_src_1   (d_uses_src_1),
    .d_uses_src_2   (d_uses_src_2),
    .x_dst_reg      (x_dst_reg),
    .x_mem_read     (x_mem_read),
    .x_reg_write    (x_reg_write),
    .x_is_mul       (x_is_mul),
    .x_branch_taken (x_branch_taken),
    .m_mem_req      (m_mem_req),
    .m_mem_ready    (m_mem_ready),
    .pc_stall       (pc_stall),
    .f2d_stall      (f2d_stall),
    .d2x_stall      (d2x_stall),
    .x2m_stall      (x2m_stall),
    .f2d_flush      (f2d_flush),
    .d2x_flush      (d2x_flush),
    .x2m_flush      (x2m_flush),
    .m2w_flush      (m2w_flush),
    .stall_cycles   (stall_cycles)
  );

  always #5 clock = ~clock;

  assign outs = {pc_stall, f2d_stall, d2x_stall, x2m_stall,
                 f2d_flush, d2x_flush, x2m_flush, m2w_flush};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [5:0] dst, s1, s2,
                              input logic u1, u2, mr, rw, mul, br, mq, rdy,
                              input logic [7:0] exp);
    vec_t v;
    v.dst = dst; v.s1 = s1; v.s2 = s2; v.u1 = u1; v.u2 = u2;
    v.mr = mr; v.rw = rw; v.mul = mul; v.br = br; v.mq = mq; v.rdy = rdy;
    v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr();
    d_src_reg_1 = '0; d_src_reg_2 = '0; x_dst_reg = '0;
    d_uses_src_1 = 0; d_uses_src_2 = 0; x_mem_read = 0; x_reg_write = 0;
    x_is_mul = 0; x_branch_taken = 0; m_mem_req = 0; m_mem_ready = 0;
  endtask

  // Check outputs mid-cycle, update the counter model, advance one clock.
  task automatic cyc(input string name, input logic [7:0] exp);
    #1;
    chk(name, 32'(outs), 32'(exp));
    if (exp[7] && exp_cnt != '1) exp_cnt = exp_cnt + CNT_W'(1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    //             dst s1  s2  u1 u2 mr rw mul br mq rdy exp
    tbl[0]  = mk(5,  1,  5,  1, 1, 1, 1, 0, 0, 0, 0, O_LU);
    tbl[1]  = mk(0,  1,  0,  1, 1, 1, 1, 0, 0, 0, 0, O_NONE);
    tbl[2]  = mk(7,  7,  3,  1, 1, 1, 1, 0, 0, 0, 0, O_LU);
    tbl[3]  = mk(7,  7,  3,  0, 1, 1, 1, 0, 0, 0, 0, O_NONE);
    tbl[4]  = mk(9,  9,  9,  1, 1, 0, 1, 0, 0, 0, 0, O_NONE);
    tbl[5]  = mk(9,  9,  9,  1, 1, 1, 0, 0, 0, 0, 0, O_NONE);
    tbl[6]  = mk(5,  5,  2,  1, 1, 1, 1, 0, 1, 0, 0, O_BR);
    tbl[7]  = mk(5,  5,  2,  1, 1, 1, 1, 0, 1, 1, 0, O_MEM);
    tbl[8]  = mk(0,  0,  0,  0, 0, 0, 0, 0, 0, 1, 1, O_NONE);
    tbl[9]  = mk(63, 2,  63, 0, 1, 1, 1, 0, 0, 1, 1, O_LU);
    tbl[10] = mk(0,  0,  0,  0, 0, 0, 0, 1, 1, 0, 0, O_BR);
    tbl[11] = mk(0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, O_NONE);
    tbl[12] = mk(0,  0,  0,  0, 0, 0, 0, 1, 0, 1, 0, O_MEM);
    tbl[13] = mk(0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, O_NONE);
    tbl[14] = mk(32, 32, 0,  1, 0, 1, 1, 0, 0, 0, 0, O_LU);

    clr();
    reset = 1'b1;
    exp_cnt = '0;
    #3;
    chk("reset_outs", 32'(outs), 32'(O_RST));
    chk("reset_cnt", 32'(stall_cycles), 32'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Single-cycle hazard table, all applied from RUN.
    foreach (tbl[i]) begin
      clr();
      x_dst_reg = tbl[i].dst; d_src_reg_1 = tbl[i].s1; d_src_reg_2 = tbl[i].s2;
      d_uses_src_1 = tbl[i].u1; d_uses_src_2 = tbl[i].u2;
      x_mem_read = tbl[i].mr; x_reg_write = tbl[i].rw; x_is_mul = tbl[i].mul;
      x_branch_taken = tbl[i].br; m_mem_req = tbl[i].mq; m_mem_ready = tbl[i].rdy;
      cyc($sformatf("vec%0d", i), tbl[i].exp);
    end
    chk("cnt_after_table", 32'(stall_cycles), 32'(exp_cnt));

    // Multiply, latency 4: stall cycles 0..2, free in cycle 3, RUN at cycle 4.
    clr();
    x_is_mul = 1;
    cyc("mul_c0", O_MUL);
    cyc("mul_c1", O_MUL);
    cyc("mul_c2", O_MUL);
    cyc("mul_c3", O_NONE);
    chk("cnt_after_mul", 32'(stall_cycles), 32'(exp_cnt));
    // A new multiply starting at cycle 4 proves the FSM is back in RUN.
    cyc("mul2_c0", O_MUL);
    cyc("mul2_c1", O_MUL);
    // Now cnt=1 in MUL_WAIT: memory wait for 5 cycles freezes it.
    m_mem_req = 1;
    for (int k = 0; k < 5; k++) cyc($sformatf("mulmem_%0d", k), O_MEM);
    m_mem_req = 0;
    cyc("mulmem_after", O_MUL);
    cyc("mulmem_done", O_NONE);
    chk("cnt_after_mulmem", 32'(stall_cycles), 32'(exp_cnt));

    // Start a multiply, then reset asynchronously while in MUL_WAIT.
    cyc("mul3_c0", O_MUL);
    reset = 1'b1;
    #1;
    chk("async_reset_outs", 32'(outs), 32'(O_RST));
    chk("async_reset_cnt", 32'(stall_cycles), 32'(0));
    exp_cnt = '0;
    @(negedge clock);
    reset = 1'b0;
    x_is_mul = 0;
    cyc("post_reset_run", O_NONE);

    // Taken branch held under a 3-cycle memory wait; redirect in cycle 4.
    clr();
    x_branch_taken = 1; m_mem_req = 1;
    for (int k = 0; k < 3; k++) cyc($sformatf("brmem_%0d", k), O_MEM);
    m_mem_ready = 1;
    cyc("brmem_redirect", O_BR);
    chk("cnt_after_br", 32'(stall_cycles), 32'(exp_cnt));

    // Counter saturation: 2^CNT_W + 5 memory-stall cycles.
    clr();
    m_mem_req = 1;
    for (int k = 0; k < (1 << CNT_W) + 5; k++) @(posedge clock);
    #1;
    chk("cnt_saturated", 32'(stall_cycles), 32'({CNT_W{1'b1}}));
    @(posedge clock);
    #1;
    chk("cnt_stays_saturated", 32'(stall_cycles), 32'({CNT_W{1'b1}}));
    clr();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage core. It watches decode, execute and memory stage status each cycle and decides what every pipeline register does: advance, hold (stall) or load a bubble (flush). It handles:
- load-use hazards;
- multi-cycle multiply occupancy of X;
- data-memory wait states;
- taken branch/jump redirects from X.

It also keeps a saturating stall-cycle counter for performance monitoring. It sits beside the f2d/d2x/x2m/m2w flops. Each flop's flush is OR-ed into its synchronous clear, and each stall gates its clock enable.

## Interface
- MUL_LATENCY, 4, cycles a multiply occupies X (legal 2..16)
- CNT_W, 16, width of the stall-cycle counter
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- d_src_reg_1, d_src_reg_2  in  6  D-stage source register indices
- d_uses_src_1, d_uses_src_2  in  1  D instruction actually reads that source
- x_dst_reg  in  6  X-stage destination index
- x_mem_read, x_reg_write  in  1  X-stage control flags
- x_is_mul  in  1  X instruction is a multiply
- x_branch_taken  in  1  X resolved a taken branch/jump this cycle
- m_mem_req  in  1  M stage is accessing data memory
- m_mem_ready  in  1  data memory completes the access this cycle
- pc_stall, f2d_stall, d2x_stall, x2m_stall  out  1  hold register
- f2d_flush, d2x_flush, x2m_flush, m2w_flush  out  1  load bubble (all zeros)
- stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1

## Operation
- Register 0 is hardwired zero. It never creates a hazard.
- `mem_stall = m_mem_req & ~m_mem_ready`.
- `ld_use = x_mem_read & x_reg_write & (x_dst_reg != 0) & ((d_uses_src_1 & x_dst_reg == d_src_reg_1) | (d_uses_src_2 & x_dst_reg == d_src_reg_2))`.
- FSM states are RUN and MUL_WAIT, with down-counter `cnt` (4 bits).
  - RUN & x_is_mul & ~mem_stall & ~x_branch_taken: mul_stall=1, cnt <= MUL_LATENCY-2, go to MUL_WAIT.
  - MUL_WAIT & ~mem_stall: mul_stall = (cnt != 0).
    - If cnt != 0: cnt decrements.
    - If cnt == 0: go to RUN.
  - While mem_stall: state and cnt hold, and mul_stall is forced to 0 (mem_stall dominates).
- Output priority, highest first (only the highest active case drives outputs; all others are 0):
  1. mem_stall: pc/f2d/d2x/x2m_stall=1, m2w_flush=1.
  2. x_branch_taken: f2d_flush=1, d2x_flush=1. The PC loads the target (pc_stall=0).
  3. mul_stall: pc/f2d/d2x_stall=1, x2m_flush=1.
  4. ld_use: pc_stall=1, f2d_stall=1, d2x_flush=1.
  5. None active: all outputs 0 (pipeline advances).
- A branch held in X under mem_stall keeps x_branch_taken high. Its redirect is taken in the first cycle mem_stall drops.
- x_is_mul and x_branch_taken are mutually exclusive. If both are asserted, the priority order applies and the FSM stays in RUN.
- stall_cycles increments each cycle pc_stall=1 and saturates at all-ones.

## Timing
- All stall/flush outputs are combinational from the inputs and the registered state, with no added latency.
- State, cnt and stall_cycles update on the rising edge of clock.
- During reset:
  - state=RUN, cnt=0, stall_cycles=0.
  - All four flush outputs are forced to 1 and all stalls to 0, so every pipeline flop clears.
- Reset mid-MUL_WAIT abandons the multiply. The first cycle after reset is RUN with no stall.
- A multiply is resident in X for exactly MUL_LATENCY cycles, with stall asserted in the first MUL_LATENCY-1 of them. Cycles frozen by mem_stall are added on top.
- A load-use hazard costs exactly 1 bubble. The dependent instruction reaches X one cycle after the load reaches M.
- A taken branch costs 2 bubbles (F and D instructions killed).

## Test plan
- Load-use: X=`ld r5`, D reads r5 as src_2 -> one cycle with pc_stall=f2d_stall=d2x_flush=1, then all 0. Repeat with x_dst_reg=0 -> no stall.
- Multiply, MUL_LATENCY=4: x_is_mul at cycle 0 -> d2x_stall=x2m_flush=1 in cycles 0..2, 0 in cycle 3, state back to RUN at cycle 4, stall_cycles=3.
- Memory wait: m_mem_req=1, m_mem_ready=0 for 5 cycles during MUL_WAIT with cnt=1 -> all stalls=1 and m2w_flush=1 for 5 cycles, cnt stays 1. After ready, 1 more mul_stall cycle.
- Branch vs load-use: x_branch_taken=1 with an ld_use-matching D -> f2d_flush=d2x_flush=1, pc_stall=0.
- Branch under mem_stall for 3 cycles -> no flush during those cycles; flush is asserted in cycle 4.
- Async reset asserted mid-MUL_WAIT without a clock edge -> all flushes=1 immediately and stall_cycles=0. After release: RUN, no stall. Also force 2^CNT_W+5 stall cycles -> stall_cycles holds at all-ones.
